// File: rtl/mux16_reg.sv
// 16:1 single-bit multiplexer built as a 4-level tree of 2:1 cells,
// followed by a single output register with synchronous active-high reset.
module mux16_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] X,
  input  logic [3:0]  C,
  output logic        Y
);

  logic [7:0] lvl1;
  logic [3:0] lvl2;
  logic [1:0] lvl3;
  logic       lvl4;
  logic       y_d;
  logic       y_q;

  // Each level halves the candidates using one select bit, LSB first.
  always_comb begin
    lvl1 = '0;
    lvl2 = '0;
    lvl3 = '0;
    for (int k = 0; k < 8; k++) begin
      lvl1[k] = C[0] ? X[2*k+1] : X[2*k];
    end
    for (int k = 0; k < 4; k++) begin
      lvl2[k] = C[1] ? lvl1[2*k+1] : lvl1[2*k];
    end
    for (int k = 0; k < 2; k++) begin
      lvl3[k] = C[2] ? lvl2[2*k+1] : lvl2[2*k];
    end
    lvl4 = C[3] ? lvl3[1] : lvl3[0];
  end

  always_comb begin
    y_d = lvl4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_mux16_reg.sv
// Directed and random checks of mux16_reg against a shift-based reference
// of Y = X[C] delayed by one clock, with reset forcing zero.
module tb_mux16_reg;

  logic        clk;
  logic        rst;
  logic [15:0] X;
  logic [3:0]  C;
  logic        Y;

  int total = 0;
  int bad   = 0;

  logic [0:0] exp_q[$];

  mux16_reg dut (
    .clk (clk),
    .rst (rst),
    .X   (X),
    .C   (C),
    .Y   (Y)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference: registered value is the C-th bit of X, or zero under reset
  function automatic logic model_y(input logic [15:0] x, input logic [3:0] c, input logic r);
    logic [15:0] shifted;
    if (r) return 1'b0;
    shifted = x >> c;
    return shifted[0];
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
      $error("%s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // driver: apply inputs, take one rising edge, settle just after it
  task automatic drive_edge(input logic [15:0] x, input logic [3:0] c, input logic r);
    X   = x;
    C   = c;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  logic sweep_a [16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic sweep_b [16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [15:0] rx;
    logic [3:0]  rc;
    logic        rr;
    logic [0:0]  e;

    rst = 1'b1;
    X   = 16'hFFFF;
    C   = 4'd5;

    // reset held for two edges with all-ones data
    drive_edge(16'hFFFF, 4'd5, 1'b1);
    check("reset_edge1", Y, 1'b0);
    drive_edge(16'hFFFF, 4'd5, 1'b1);
    check("reset_edge2", Y, 1'b0);

    // sweep A, first edge after reset loads data directly
    for (int c = 0; c < 16; c++) begin
      drive_edge(16'hEC83, c[3:0], 1'b0);
      check($sformatf("sweep_a_c%0d", c), Y, sweep_a[c]);
    end

    // mid-operation reset from Y=1 at C=15
    drive_edge(16'hEC83, 4'd15, 1'b1);
    check("mid_reset", Y, 1'b0);
    drive_edge(16'hEC83, 4'd0, 1'b0);
    check("reset_release", Y, 1'b1);

    // rst raised between edges must not touch Y
    rst = 1'b1;
    #2;
    check("rst_between_edges", Y, 1'b1);
    rst = 1'b0;

    // sweep B
    for (int c = 0; c < 16; c++) begin
      drive_edge(16'h93B1, c[3:0], 1'b0);
      check($sformatf("sweep_b_c%0d", c), Y, sweep_b[c]);
    end

    // simultaneous change of X and C
    drive_edge(16'hEC83, 4'd2, 1'b0);
    check("simul_before", Y, 1'b0);
    drive_edge(16'h93B1, 4'd4, 1'b0);
    check("simul_after", Y, 1'b1);

    // select glitch 0->2->0 between edges
    drive_edge(16'hEC83, 4'd0, 1'b0);
    check("glitch_base", Y, 1'b1);
    C = 4'd2;
    #2;
    check("glitch_c2_hold", Y, 1'b1);
    C = 4'd0;
    #2;
    check("glitch_c0_hold", Y, 1'b1);
    @(posedge clk);
    #1;
    check("glitch_after_edge", Y, 1'b1);

    // random stimulus scored through the expected queue
    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom);
      rc = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 19) == 0);
      exp_q.push_back(model_y(rx, rc, rr));
      drive_edge(rx, rc, rr);
      e = exp_q.pop_front();
      check($sformatf("rand_%0d x=%h c=%0d r=%b", i, rx, rc, rr), Y, e[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
